// File: rtl/count_chk_pkg.sv
// Shared types and defaults for the counter sequence checker.
// The optional wrap tracking in the top is enabled by COUNT_CHK_WRAP_EN.
package count_chk_pkg;

    typedef enum logic {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } chk_state_e;

    localparam int HIT_THRESH = 2;

    localparam int DEF_WIDTH  = 3;
    localparam int DEF_SETTLE = 2;
    localparam int DEF_ERR_W  = 8;
    localparam int DEF_WRAP_W = 8;

endpackage

// File: rtl/count_settle_filter.sv
// Two-flop synchronizer plus stability filter for the monitored counter.
// Emits a one-cycle event when a new settled value differs from cur_i.
module count_settle_filter
    import count_chk_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic [WIDTH-1:0] cur_i,
    output logic             ev_o,
    output logic [WIDTH-1:0] new_o
);

    localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(SETTLE);
    localparam logic [SW-1:0] STAB_HIT = SW'(SETTLE - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [SW-1:0]    stab_q, stab_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            stab_q  <= '0;
        end else begin
            sync1_q <= cnt_i;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            stab_q  <= stab_d;
        end
    end

    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            stab_d = '0;
        end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + 1'b1;
        end
    end

    // Fires once: the cycle after, cur_i has caught up with cand_q.
    assign ev_o  = (cand_q != cur_i) && (sync2_q == cand_q)
                && (stab_q == STAB_HIT);
    assign new_o = cand_q;

endmodule

// File: rtl/count_sequence_checker.sv
// Verifies a free-running up counter steps by +1, tracking lock and errors.
// Define COUNT_CHK_WRAP_EN to build the wrap pulse and wrap counter.
module count_sequence_checker
    import count_chk_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SETTLE = DEF_SETTLE,
    parameter int ERR_W  = DEF_ERR_W,
    parameter int WRAP_W = DEF_WRAP_W
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              enable,
    input  logic              clear,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [WIDTH-1:0]  cur_value
);

    localparam logic [1:0] HITS_LAST = 2'(HIT_THRESH - 1);

    chk_state_e       state_q, state_d;
    logic [1:0]       hits_q, hits_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             ev;
    logic [WIDTH-1:0] new_val;
    logic [WIDTH-1:0] exp_val;

    count_settle_filter #(
        .WIDTH  (WIDTH),
        .SETTLE (SETTLE)
    ) u_filter (
        .clk_i (clk),
        .rst_i (RST),
        .cnt_i (cnt_in),
        .cur_i (v_q),
        .ev_o  (ev),
        .new_o (new_val)
    );

    assign exp_val = v_q + WIDTH'(1);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q     <= ACQUIRE;
            hits_q      <= '0;
            v_q         <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hits_q      <= hits_d;
            v_q         <= v_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hits_d      = hits_q;
        v_d         = v_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        if (ev) begin
            v_d = new_val;
        end
        if (clear) begin
            state_d   = ACQUIRE;
            hits_d    = '0;
            err_cnt_d = '0;
        end else if (!enable) begin
            state_d = ACQUIRE;
            hits_d  = '0;
        end else if (ev) begin
            unique case (state_q)
                ACQUIRE: begin
                    if (new_val != exp_val) begin
                        hits_d = '0;
                    end else if (hits_q == HITS_LAST) begin
                        state_d = LOCKED;
                        hits_d  = '0;
                    end else begin
                        hits_d = hits_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (new_val != exp_val) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        state_d = ACQUIRE;
                        hits_d  = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;
    assign cur_value = v_q;

`ifdef COUNT_CHK_WRAP_EN
    logic              wrap_hit;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

    // A correct max->0 step taken while already locked.
    assign wrap_hit = !clear && enable && ev && (state_q == LOCKED)
                   && (new_val == exp_val) && (v_q == '1);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            wrap_pulse_q <= 1'b0;
            wrap_cnt_q   <= '0;
        end else begin
            wrap_pulse_q <= wrap_pulse_d;
            wrap_cnt_q   <= wrap_cnt_d;
        end
    end

    always_comb begin
        wrap_pulse_d = 1'b0;
        wrap_cnt_d   = wrap_cnt_q;
        if (clear) begin
            wrap_cnt_d = '0;
        end else if (wrap_hit) begin
            wrap_pulse_d = 1'b1;
            wrap_cnt_d   = wrap_cnt_q + 1'b1;
        end
    end

    assign wrap_pulse = wrap_pulse_q;
    assign wrap_count = wrap_cnt_q;
`else
    assign wrap_pulse = 1'b0;
    assign wrap_count = '0;
`endif

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed bench for count_sequence_checker: vector table plus corner sequences.
module tb_count_sequence_checker;

    localparam int WIDTH  = 3;
    localparam int SETTLE = 2;
    localparam int ERR_W  = 8;
    localparam int WRAP_W = 8;
`ifdef COUNT_CHK_WRAP_EN
    localparam int WE = 1;
`else
    localparam int WE = 0;
`endif
    localparam int NV = 20;

    typedef struct {
        logic [2:0] cnt;
        logic       en;
        logic       lock;
        logic [2:0] cur;
        int         errc;
        int         wrapc;
        int         errp;
        int         wrapp;
    } vec_t;

    logic              clk = 1'b0;
    logic              RST;
    logic [WIDTH-1:0]  cnt_in;
    logic              enable;
    logic              clear;
    logic              locked;
    logic              err_pulse;
    logic [ERR_W-1:0]  err_count;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_count;
    logic [WIDTH-1:0]  cur_value;

    int n_tests = 0;
    int n_fail  = 0;
    int errp_n  = 0;
    int wrapp_n = 0;

    vec_t tv [NV];

    always #5 clk = ~clk;

    count_sequence_checker #(
        .WIDTH  (WIDTH),
        .SETTLE (SETTLE),
        .ERR_W  (ERR_W),
        .WRAP_W (WRAP_W)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .cnt_in     (cnt_in),
        .enable     (enable),
        .clear      (clear),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .wrap_pulse (wrap_pulse),
        .wrap_count (wrap_count),
        .cur_value  (cur_value)
    );

    // Every high cycle counts, so a stretched pulse shows up as extra.
    always @(negedge clk) begin
        if (err_pulse === 1'b1) errp_n++;
        if (wrap_pulse === 1'b1) wrapp_n++;
    end

    function automatic vec_t mk(input int c, input int e, input int l,
                                input int v, input int ec, input int wc,
                                input int ep, input int wp);
        vec_t r;
        r.cnt   = 3'(c);
        r.en    = 1'(e);
        r.lock  = 1'(l);
        r.cur   = 3'(v);
        r.errc  = ec;
        r.wrapc = wc;
        r.errp  = ep;
        r.wrapp = wp;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int l, input int v,
                             input int ec, input int wc);
        chk({tag, " locked"}, 32'(locked), 32'(l));
        chk({tag, " cur_value"}, 32'(cur_value), 32'(v));
        chk({tag, " err_count"}, 32'(err_count), 32'(ec));
        chk({tag, " wrap_count"}, 32'(wrap_count), 32'(wc));
    endtask

    initial begin
        logic [2:0] v;
        int ep;
        int wp;

        tv[0]  = mk(0, 1, 0, 0, 0, 0, 0, 0);
        tv[1]  = mk(1, 1, 0, 1, 0, 0, 0, 0);
        tv[2]  = mk(2, 1, 1, 2, 0, 0, 0, 0);
        tv[3]  = mk(3, 1, 1, 3, 0, 0, 0, 0);
        tv[4]  = mk(4, 1, 1, 4, 0, 0, 0, 0);
        tv[5]  = mk(5, 1, 1, 5, 0, 0, 0, 0);
        tv[6]  = mk(6, 1, 1, 6, 0, 0, 0, 0);
        tv[7]  = mk(7, 1, 1, 7, 0, 0, 0, 0);
        tv[8]  = mk(0, 1, 1, 0, 0, WE, 0, WE);
        tv[9]  = mk(1, 1, 1, 1, 0, WE, 0, WE);
        tv[10] = mk(2, 1, 1, 2, 0, WE, 0, WE);
        tv[11] = mk(3, 1, 1, 3, 0, WE, 0, WE);
        tv[12] = mk(5, 1, 0, 5, 1, WE, 1, WE);
        tv[13] = mk(6, 1, 0, 6, 1, WE, 1, WE);
        tv[14] = mk(7, 1, 1, 7, 1, WE, 1, WE);
        tv[15] = mk(0, 1, 1, 0, 1, 2*WE, 1, 2*WE);
        tv[16] = mk(1, 0, 0, 1, 1, 2*WE, 1, 2*WE);
        tv[17] = mk(2, 0, 0, 2, 1, 2*WE, 1, 2*WE);
        tv[18] = mk(3, 1, 0, 3, 1, 2*WE, 1, 2*WE);
        tv[19] = mk(4, 1, 1, 4, 1, 2*WE, 1, 2*WE);

        RST    = 1'b1;
        cnt_in = '0;
        enable = 1'b1;
        clear  = 1'b0;
        hold(3);
        chk_state("reset", 0, 0, 0, 0);
        chk("reset err_pulse", 32'(err_pulse), 0);
        chk("reset wrap_pulse", 32'(wrap_pulse), 0);
        RST = 1'b0;
        hold(2);

        for (int i = 0; i < NV; i++) begin
            cnt_in = tv[i].cnt;
            enable = tv[i].en;
            hold(8);
            chk_state($sformatf("row%0d", i), tv[i].lock, tv[i].cur,
                      tv[i].errc, tv[i].wrapc);
            chk($sformatf("row%0d err_pulses", i), errp_n, tv[i].errp);
            chk($sformatf("row%0d wrap_pulses", i), wrapp_n, tv[i].wrapp);
        end
        ep = 1;
        wp = 2 * WE;

        // One-cycle glitch 4->6->4 while locked at 4.
        cnt_in = 3'd6;
        hold(1);
        cnt_in = 3'd4;
        hold(10);
        chk_state("glitch", 1, 4, 1, 2 * WE);
        chk("glitch err_pulses", errp_n, ep);

        cnt_in = 3'd5;
        hold(8);
        chk_state("pre_clear", 1, 5, 1, 2 * WE);

        // clear lands on the same edge as the 5->6 accept.
        cnt_in = 3'd6;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1 clear = 1'b1;
        @(negedge clk);
        #1 clear = 1'b0;
        hold(6);
        chk_state("clear", 0, 6, 0, 0);
        chk("clear err_pulses", errp_n, ep);

        cnt_in = 3'd7;
        hold(8);
        chk_state("post_clear7", 0, 7, 0, 0);
        cnt_in = 3'd0;
        hold(8);
        chk_state("post_clear0", 1, 0, 0, 0);
        chk("post_clear wrap_pulses", wrapp_n, wp);

        cnt_in = 3'd2;
        hold(8);
        ep++;
        chk_state("skip0to2", 0, 2, 1, 0);
        chk("skip err_pulses", errp_n, ep);
        for (int k = 3; k <= 5; k++) begin
            cnt_in = 3'(k);
            hold(8);
        end
        chk_state("relock5", 1, 5, 1, 0);

        // Asynchronous reset between clock edges.
        #2 RST = 1'b1;
        #1;
        chk_state("async_rst", 0, 0, 0, 0);
        chk("async_rst err_pulse", 32'(err_pulse), 0);
        cnt_in = 3'd0;
        hold(3);
        RST = 1'b0;
        hold(4);

        cnt_in = 3'd1;
        hold(8);
        chk_state("lap1", 0, 1, 0, 0);
        cnt_in = 3'd2;
        hold(8);
        chk_state("lap2", 1, 2, 0, 0);
        for (int k = 3; k <= 8; k++) begin
            cnt_in = 3'(k);
            hold(8);
        end
        wp += WE;
        chk_state("lap_end", 1, 0, 0, WE);
        chk("lap wrap_pulses", wrapp_n, wp);

        // 300 errors: +2 (error) then two +1 steps to relock.
        v = 3'd0;
        for (int i = 0; i < 300; i++) begin
            v = v + 3'd2;
            cnt_in = v;
            hold(5);
            v = v + 3'd1;
            cnt_in = v;
            hold(5);
            v = v + 3'd1;
            cnt_in = v;
            hold(5);
            if (i == 99) begin
                chk("err_count at 100", 32'(err_count), 100);
            end
        end
        ep += 300;
        hold(4);
        chk_state("saturate", 1, 32'(v), 255, WE);
        chk("saturate err_pulses", errp_n, ep);
        chk("saturate wrap_pulses", wrapp_n, wp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
